// File: rtl/serial_arith_pkg.sv
// ============================================================================
//  Module      : serial_arith_pkg
//  Description : Shared constants for the bit-serial add/subtract datapaths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/full_adder_bit.sv
// ============================================================================
//  Module      : full_adder_bit
//  Description : Combinational 1-bit full adder cell.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder_bit (
    input  wire logic i_a,
    input  wire logic i_b,
    input  wire logic i_cin,
    output logic      o_sum,
    output logic      o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial two's-complement adder, LSB first, one bit/clock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             start_i,
    input  wire logic [WIDTH-1:0] a_i,
    input  wire logic [WIDTH-1:0] b_i,
    input  wire logic             carry_in_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [WIDTH-1:0]      sum_o,
    output logic                  carry_out_o,
    output logic                  overflow_o
);

    localparam int               c_SSW  = WIDTH - 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [c_SSW-1:0] r_ss;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_s;
    logic             w_cout;

    full_adder_bit u_fa (
        .i_a    (r_sa[0]),
        .i_b    (r_sb[0]),
        .i_cin  (r_c),
        .o_sum  (w_s),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_ss    <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                // DONE accepts a new start directly for back-to-back operation
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_sa    <= a_i;
                        r_sb    <= b_i;
                        r_ss    <= '0;
                        r_c     <= carry_in_i;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_ss  <= c_SSW'({w_s, r_ss} >> 1);
                    r_c   <= w_cout;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        // r_c still holds the carry into the MSB here
                        r_sum   <= {w_s, r_ss};
                        r_cout  <= w_cout;
                        r_ovf   <= r_c ^ w_cout;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o      = (r_state == S_RUN);
    assign done_o      = (r_state == S_DONE);
    assign sum_o       = r_sum;
    assign carry_out_o = r_cout;
    assign overflow_o  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder with a transaction model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_done = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .a_i         (a),
        .b_i         (b),
        .carry_in_i  (cin),
        .busy_o      (busy),
        .done_o      (done),
        .sum_o       (sum),
        .carry_out_o (cout),
        .overflow_o  (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: an accepted add finishes WIDTH edges later
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_sum = '0, m_psum = '0;
    logic         m_co = 1'b0, m_ov = 1'b0, m_pco = 1'b0, m_pov = 1'b0;
    logic         chk_en = 1'b0;
    logic [W:0]   t;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            chk_en = 1'b1;
            m_left = 0; m_done = 1'b0;
            m_sum = '0; m_co = 1'b0; m_ov = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            m_done = (m_left == 0);
            if (m_done) begin
                m_sum = m_psum; m_co = m_pco; m_ov = m_pov;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_left = W;
                t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_psum = t[W-1:0];
                m_pco  = t[W];
                m_pov  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("sum",  {24'd0, sum},  {24'd0, m_sum});
            chk("cout", {31'd0, cout}, {31'd0, m_co});
            chk("ovf",  {31'd0, ovf},  {31'd0, m_ov});
            if (done) n_done++;
        end
    end

    task automatic wait_done(input string name, output int done_cyc);
        int waited = 0;
        while (!done && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
        done_cyc = cyc;
    endtask

    task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input logic [W-1:0] es, input logic eco, input logic eov);
        int busy_cnt = 0;
        int waited = 0;
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && waited < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            waited++;
        end
        chk({name, "_busy_cycles"}, busy_cnt, W);
        chk({name, "_sum"}, {24'd0, sum}, {24'd0, es});
        chk({name, "_cout"}, {31'd0, cout}, {31'd0, eco});
        chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, eov});
    endtask

    initial begin
        int d0, d1, d2;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum",  {24'd0, sum},  32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf",  {31'd0, ovf},  32'd0);

        run_op("add3c0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
        run_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        run_op("add8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // start re-asserted during RUN and operand changes must be ignored
        d0 = n_done;
        @(negedge clk); a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk); start = 1'b0; a = 8'hFF;
        wait_done("ignore", d1);
        chk("ignore_sum", {24'd0, sum}, 32'h30);
        repeat (12) @(negedge clk);
        chk("ignore_pulses", n_done - d0, 1);
        chk("ignore_idle", {31'd0, busy}, 32'd0);

        // start held across DONE gives back-to-back operation
        @(negedge clk); a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        a = 8'h01; b = 8'h02; start = 1'b1;
        wait_done("b2b_first", d1);
        chk("b2b_sum1", {24'd0, sum}, 32'h30);
        @(negedge clk); start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done("b2b_second", d2);
        chk("b2b_spacing", d2 - d1, W + 1);
        chk("b2b_sum2", {24'd0, sum}, 32'h03);

        // reset mid-run aborts with no done pulse
        @(negedge clk); a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        d0 = n_done;
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sum",  {24'd0, sum},  32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        repeat (12) @(negedge clk);
        chk("abort_pulses", n_done - d0, 0);
        run_op("add0506", 8'h05, 8'h06, 1'b0, 8'h0B, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
